// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge control FSM.
// Accepts one AHB transfer at a time, captures its address/select/direction,
// then runs the APB SETUP/ACCESS handshake. Writes take one extra WWAIT cycle
// so the AHB data phase can deliver Hwdata before APB SETUP.
module apb_fsm_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic              Hwrite,
    input  logic [2:0]        tempselx,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic              Pready,
    output logic              Hreadyout,
    output logic [2:0]        Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata
);

    typedef enum logic [2:0] {
        IDLE, WWAIT, WSETUP, WACCESS, RSETUP, RACCESS
    } state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        sel_q;
    logic              wr_q;
    logic              accept;

    // A new transfer is taken from IDLE, or in the cycle an ACCESS completes
    // so back-to-back transfers need no IDLE bubble.
    assign accept = valid &&
                    ((state == IDLE) ||
                     (((state == RACCESS) || (state == WACCESS)) && Pready));

    // State register.
    always_ff @(posedge Hclk) begin
        if (Hreset) state <= IDLE;
        else        state <= next_state;
    end

    // Transfer capture: address phase on accept, write data in WWAIT.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            addr_q  <= '0;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= Haddr;
                sel_q  <= tempselx;
                wr_q   <= Hwrite;
            end
            if (state == WWAIT) wdata_q <= Hwdata;
        end
    end

    // Next-state and output decode. All P* outputs derive from registered
    // state only; Hreadyout alone passes Pready through during ACCESS.
    always_comb begin
        next_state = state;
        Hreadyout  = 1'b0;
        Pselx      = 3'b000;
        Penable    = 1'b0;
        Pwrite     = 1'b0;
        Paddr      = addr_q;
        Pwdata     = wdata_q;

        case (state)
            IDLE: begin
                Hreadyout = 1'b1;
            end
            WWAIT: begin
                next_state = WSETUP;
            end
            WSETUP: begin
                next_state = WACCESS;
                Pselx      = sel_q;
                Pwrite     = wr_q;
            end
            WACCESS: begin
                if (Pready) next_state = IDLE;
                Hreadyout = Pready;
                Pselx     = sel_q;
                Penable   = 1'b1;
                Pwrite    = wr_q;
            end
            RSETUP: begin
                next_state = RACCESS;
                Pselx      = sel_q;
            end
            RACCESS: begin
                if (Pready) next_state = IDLE;
                Hreadyout = Pready;
                Pselx     = sel_q;
                Penable   = 1'b1;
            end
            default: next_state = IDLE;
        endcase

        // Accept overrides the completion-to-IDLE path.
        if (accept) next_state = Hwrite ? WWAIT : RSETUP;
    end

endmodule
